// File: rtl/bus_sram_target.sv
// Bus target that claims a word-addressed SRAM window and serves burst reads/writes.
// All outputs are registered and idle at zero so several targets can be OR-combined.
module bus_sram_target #(
    parameter logic [31:0] baseAddress = 32'h5000_0000,
    parameter int unsigned nrOfWords   = 512
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        begin_transaction_i,
    input  logic        end_transaction_i,
    input  logic        read_not_write_i,
    input  logic        data_valid_i,
    input  logic [31:0] address_data_i,
    input  logic [3:0]  byte_enables_i,
    input  logic [7:0]  burst_size_i,
    output logic        end_transaction_o,
    output logic        data_valid_o,
    output logic        bus_error_o,
    output logic        busy_o,
    output logic [31:0] address_data_o
);

    localparam int unsigned IW     = $clog2(nrOfWords);
    localparam logic [31:0] WINDOW = 32'(4 * nrOfWords);

    typedef enum logic [2:0] {IDLE, READ, READ_END, WRITE, WRITE_ERR, ERR_END} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [8:0]      cnt_q, cnt_d;
    logic            end_q, end_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [31:0]     data_q, data_d;
    logic            mem_we;
    logic [31:0]     offset;
    logic            hit;
    logic [IW-1:0]   start_idx;

    logic [31:0] mem [nrOfWords];

    assign offset    = address_data_i - baseAddress;
    assign hit       = offset < WINDOW;
    assign start_idx = IW'(offset >> 2);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        end_d   = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        data_d  = '0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (begin_transaction_i) begin
                    cnt_d = {1'b0, burst_size_i} + 9'd1;
                    idx_d = start_idx;
                    if (read_not_write_i) state_d = hit ? READ : ERR_END;
                    else                  state_d = hit ? WRITE : WRITE_ERR;
                end
            end
            READ: begin
                if (end_transaction_i) begin
                    state_d = IDLE;
                end else begin
                    // The SRAM read register doubles as the registered bus output.
                    valid_d = 1'b1;
                    data_d  = mem[idx_q];
                    idx_d   = idx_q + IW'(1);
                    cnt_d   = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) state_d = READ_END;
                end
            end
            READ_END: begin
                end_d   = 1'b1;
                state_d = IDLE;
            end
            WRITE: begin
                if (data_valid_i && cnt_q != 9'd0) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + IW'(1);
                    cnt_d  = cnt_q - 9'd1;
                end
                if (end_transaction_i) state_d = IDLE;
            end
            WRITE_ERR: begin
                // Count is non-zero only on the first cycle, giving a single error pulse.
                err_d = (cnt_q != 9'd0);
                cnt_d = '0;
                if (end_transaction_i) state_d = IDLE;
            end
            ERR_END: begin
                err_d   = 1'b1;
                end_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            end_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_enables_i[i]) mem[idx_q][8*i +: 8] <= address_data_i[8*i +: 8];
            end
        end
    end

    assign end_transaction_o = end_q;
    assign data_valid_o      = valid_q;
    assign bus_error_o       = err_q;
    assign busy_o            = 1'b0;
    assign address_data_o    = data_q;

endmodule

// File: tb/tb_bus_sram_target.sv
// Directed scoreboard bench for bus_sram_target with a 16-word window.
module tb_bus_sram_target;

    localparam logic [31:0] BASE  = 32'h5000_0000;
    localparam int unsigned WORDS = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        begin_i, end_i, rnw_i, dv_i;
    logic [31:0] ad_i;
    logic [3:0]  be_i;
    logic [7:0]  burst_i;
    logic        end_o, dv_o, err_o, busy_o;
    logic [31:0] ad_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb [$];
    logic [31:0] wq [$];
    logic [31:0] model [WORDS];

    bus_sram_target #(.baseAddress(BASE), .nrOfWords(WORDS)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .begin_transaction_i(begin_i), .end_transaction_i(end_i),
        .read_not_write_i(rnw_i), .data_valid_i(dv_i),
        .address_data_i(ad_i), .byte_enables_i(be_i), .burst_size_i(burst_i),
        .end_transaction_o(end_o), .data_valid_o(dv_o), .bus_error_o(err_o),
        .busy_o(busy_o), .address_data_o(ad_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic idle_in();
        begin_i = 0; end_i = 0; rnw_i = 0; dv_i = 0;
        ad_i = '0; be_i = '0; burst_i = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic e, input logic er);
        logic [31:0] exp_d;
        exp_d = '0;
        if (v) exp_d = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_DEAD;
        checks++;
        assert ({dv_o, end_o, err_o, busy_o} === {v, e, er, 1'b0}) else begin
            errors++;
            $error("FAIL %s ctl(dv,end,err,busy) got %b exp %b", tag,
                   {dv_o, end_o, err_o, busy_o}, {v, e, er, 1'b0});
        end
        checks++;
        assert (ad_o === exp_d) else begin
            errors++;
            $error("FAIL %s data got %h exp %h", tag, ad_o, exp_d);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input int unsigned burst,
                      input int extra_begin_k);
        int unsigned idx;
        idx = ((addr - BASE) >> 2) % WORDS;
        for (int unsigned k = 0; k <= burst; k++) sb.push_back(model[(idx + k) % WORDS]);
        idle_in();
        begin_i = 1; rnw_i = 1; ad_i = addr; burst_i = 8'(burst);
        next(); idle_in();
        expect_out({tag, "_t1"}, 0, 0, 0);
        for (int k = 0; k <= int'(burst); k++) begin
            next(); idle_in();
            expect_out({tag, "_data"}, 1, 0, 0);
            if (k == extra_begin_k) begin
                begin_i = 1; rnw_i = 0; ad_i = BASE + 32'd12; burst_i = 8'd0;
            end
        end
        next(); idle_in();
        expect_out({tag, "_end"}, 0, 1, 0);
        next();
        expect_out({tag, "_after"}, 0, 0, 0);
    endtask

    // Writes the words in wq, asserting end with the last one; updates the model.
    task automatic wr(input string tag, input logic [31:0] addr, input int unsigned burst,
                      input logic [3:0] be);
        int unsigned idx, n;
        idx = ((addr - BASE) >> 2) % WORDS;
        n = 0;
        idle_in();
        begin_i = 1; rnw_i = 0; ad_i = addr; burst_i = 8'(burst); be_i = be;
        for (int j = 0; j < wq.size(); j++) begin
            next(); idle_in();
            expect_out({tag, "_wdata"}, 0, 0, 0);
            dv_i = 1; ad_i = wq[j]; be_i = be;
            end_i = (j == wq.size() - 1);
            if (n <= burst) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[idx][8*b +: 8] = wq[j][8*b +: 8];
                idx = (idx + 1) % WORDS;
                n++;
            end
        end
        next(); idle_in();
        expect_out({tag, "_wend"}, 0, 0, 0);
        wq.delete();
    endtask

    initial begin
        rst_n = 0;
        idle_in();
        repeat (3) next();
        expect_out("reset", 0, 0, 0);
        rst_n = 1;

        wq = '{32'd1, 32'd2, 32'd3, 32'd4};
        wr("wr_basic", BASE + 32'd8, 3, 4'hF);
        rd("rd_basic", BASE + 32'd8, 3, -1);

        wq = '{32'hAABB_CCDD};
        wr("wr_be_full", BASE + 32'h20, 0, 4'hF);
        wq = '{32'h1122_3344};
        wr("wr_be_part", BASE + 32'h20, 0, 4'b0101);
        rd("rd_be", BASE + 32'h20, 0, -1);

        wq = '{32'hCAFE_0015, 32'hCAFE_0000};
        wr("wr_wrap", BASE + 32'd60, 1, 4'hF);
        rd("rd_wrap", BASE + 32'd60, 1, -1);
        rd("rd_lowbits", BASE + 32'd63, 0, -1);

        wq = '{32'h0000_0044, 32'h0000_0055};
        wr("wr_limit", BASE + 32'd16, 0, 4'hF);
        rd("rd_limit", BASE + 32'd16, 1, -1);

        idle_in();
        begin_i = 1; rnw_i = 1; ad_i = BASE - 32'd4; burst_i = 8'd2;
        next(); idle_in();
        expect_out("rmiss_t1", 0, 0, 0);
        next();
        expect_out("rmiss_t2", 0, 1, 1);
        next();
        expect_out("rmiss_t3", 0, 0, 0);

        begin_i = 1; rnw_i = 0; ad_i = BASE + 32'd64; burst_i = 8'd0; be_i = 4'hF;
        next(); idle_in();
        expect_out("wmiss_t1", 0, 0, 0);
        dv_i = 1; ad_i = 32'hDEAD_BEEF; be_i = 4'hF;
        next();
        expect_out("wmiss_t2", 0, 0, 1);
        next();
        expect_out("wmiss_t3", 0, 0, 0);
        dv_i = 0; end_i = 1;
        next(); idle_in();
        expect_out("wmiss_t4", 0, 0, 0);
        rd("rd_after_wmiss", BASE, 0, -1);

        for (int k = 0; k < 8; k++) wq.push_back(32'h1111_1111 * (k + 1));
        wr("wr_fill", BASE, 7, 4'hF);

        sb.push_back(model[0]);
        sb.push_back(model[1]);
        begin_i = 1; rnw_i = 1; ad_i = BASE; burst_i = 8'd7;
        next(); idle_in();
        expect_out("abort_t1", 0, 0, 0);
        next();
        expect_out("abort_t2", 1, 0, 0);
        next();
        expect_out("abort_t3", 1, 0, 0);
        end_i = 1;
        for (int k = 0; k < 8; k++) begin
            next(); idle_in();
            expect_out("abort_quiet", 0, 0, 0);
        end

        rd("rd_ignored_begin", BASE, 3, 1);

        sb.push_back(model[0]);
        sb.push_back(model[1]);
        begin_i = 1; rnw_i = 1; ad_i = BASE; burst_i = 8'd7;
        next(); idle_in();
        expect_out("rstmid_t1", 0, 0, 0);
        next();
        expect_out("rstmid_t2", 1, 0, 0);
        next();
        expect_out("rstmid_t3", 1, 0, 0);
        #1 rst_n = 0;
        #1 expect_out("rstmid_async", 0, 0, 0);
        next();
        expect_out("rstmid_held", 0, 0, 0);
        rst_n = 1;
        rd("rd_after_reset", BASE + 32'd4, 0, -1);
        for (int k = 0; k < 4; k++) begin
            next();
            expect_out("post_reset_quiet", 0, 0, 0);
        end

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain got %0d exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
